// File: rtl/dwc_ddrphy_pmu_acsm_pkg.sv
// Shared types and constants for the PMU ACSM instruction RAM, its loader and read sequencer.
package dwc_ddrphy_pmu_acsm_pkg;

  localparam int ACSM_DATAWID = 72;
  localparam int ACSM_DEPTH   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acsm_rdseq_st_e;

  // ceil(log2(n)), never below 1 so a 1-entry RAM still gets an address bit
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dwc_ddrphy_pmu_acsm_skid2.sv
// 2-entry valid/ready FIFO with synchronous flush; head entry is stable while not popped.
module dwc_ddrphy_pmu_acsm_skid2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q;
  logic         pop, wr_en;

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign pop     = valid_o & pop_ready_i;
  assign wr_en   = push_i & ((cnt_q != 2'd2) | pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, wr_en} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dwc_ddrphy_pmu_acsm_rdseq.sv
// ACSM instruction RAM read sequencer: streams a looped address range through a 2-entry skid FIFO.
// Optional parity check on returned words: DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN.
module dwc_ddrphy_pmu_acsm_rdseq
  import dwc_ddrphy_pmu_acsm_pkg::*;
#(
  parameter int  DATAWID = ACSM_DATAWID,
  parameter int  DEPTH   = ACSM_DEPTH,
  parameter int  LOOPWID = 8,
  localparam int AW      = log2(DEPTH)
) (
  input  logic               DfiClk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [AW-1:0]      start_addr,
  input  logic [AW-1:0]      stop_addr,
  input  logic [LOOPWID-1:0] loop_cnt,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
  output logic               par_err,
`endif
  output logic [AW-1:0]      ram_addr,
  output logic               ram_ce,
  output logic               ram_wr,
  input  logic [DATAWID-1:0] ram_rddata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATAWID-1:0] out_data,
  output logic               out_last
);

  localparam logic [AW-1:0] AMAX = AW'(DEPTH - 1);

  acsm_rdseq_st_e     st_q, st_d;
  logic [AW-1:0]      addr_q, addr_d, start_q, stop_q;
  logic [LOOPWID-1:0] pass_q, pass_d;
  logic               infl_q, infl_last_q, aborted_q;
  logic               accept, active, par_hit, abort_now, drop;
  logic               issue, at_stop, seq_last, push, pop;
  logic [1:0]         fifo_cnt, occ_eff, occ_next;

  assign accept    = (st_q == ST_IDLE) & start;
  assign active    = (st_q == ST_RUN) | (st_q == ST_DRAIN);
  assign abort_now = active & (abort | par_hit);
  assign drop      = abort_now | aborted_q;
  assign at_stop   = (addr_q == stop_q);
  assign seq_last  = at_stop & (pass_q == '0);
  assign pop       = out_valid & out_ready;
  assign push      = infl_q & ~drop;
  // Count the word leaving this cycle as free so a ready sink sees one word per cycle
  assign occ_eff   = fifo_cnt - {1'b0, pop};
  assign occ_next  = occ_eff + {1'b0, push};
  assign issue     = (st_q == ST_RUN) & ~abort_now & ((occ_eff + {1'b0, infl_q}) < 2'd2);

`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
  logic par_err_q;
  assign par_hit = active & infl_q & (^ram_rddata);
  assign par_err = par_err_q;
  always_ff @(posedge DfiClk or negedge Reset_n) begin
    if (!Reset_n)     par_err_q <= 1'b0;
    else if (accept)  par_err_q <= 1'b0;
    else if (par_hit) par_err_q <= 1'b1;
  end
`else
  assign par_hit = 1'b0;
`endif

  always_ff @(posedge DfiClk or negedge Reset_n) begin
    if (!Reset_n) st_q <= ST_IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (accept) st_d = ST_RUN;
      ST_RUN:   if (abort_now || (issue && seq_last)) st_d = ST_DRAIN;
      ST_DRAIN: if (!infl_q && (drop || occ_next == 2'd0)) st_d = ST_DONE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = active;
    done     = (st_q == ST_DONE);
    aborted  = aborted_q;
    ram_ce   = issue;
    ram_wr   = 1'b0;
    ram_addr = addr_q;
  end

  // The final issued address is held so the RAM port stays quiet after the run
  always_comb begin
    addr_d = addr_q;
    pass_d = pass_q;
    if (accept) begin
      addr_d = start_addr;
      pass_d = loop_cnt;
    end else if (issue) begin
      if (at_stop) begin
        if (!seq_last) begin
          addr_d = start_q;
          pass_d = pass_q - LOOPWID'(1);
        end
      end else begin
        addr_d = (addr_q == AMAX) ? '0 : addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge DfiClk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      pass_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      infl_q      <= issue;
      infl_last_q <= issue & seq_last;
      if (accept) begin
        start_q   <= start_addr;
        stop_q    <= stop_addr;
        aborted_q <= 1'b0;
      end else if (abort_now) begin
        aborted_q <= 1'b1;
      end
    end
  end

  dwc_ddrphy_pmu_acsm_skid2 #(.W(DATAWID + 1)) u_skid (
    .clk_i       (DfiClk),
    .rst_n_i     (Reset_n),
    .flush_i     (active & drop),
    .push_i      (push),
    .push_data_i ({infl_last_q, ram_rddata}),
    .pop_ready_i (out_ready),
    .valid_o     (out_valid),
    .data_o      ({out_last, out_data}),
    .count_o     (fifo_cnt)
  );

endmodule

// File: tb/tb_dwc_ddrphy_pmu_acsm_rdseq.sv
// Directed bench for the ACSM read sequencer with a registered-read RAM model and a scoreboard.
module tb_dwc_ddrphy_pmu_acsm_rdseq;
  import dwc_ddrphy_pmu_acsm_pkg::*;

  localparam int DW = 72, DEPTH = 16, AW = 4, LW = 8;

  logic          DfiClk = 1'b0, Reset_n = 1'b1;
  logic          start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] start_addr = '0, stop_addr = '0;
  logic [LW-1:0] loop_cnt = '0;
  logic          busy, done, aborted, ram_ce, ram_wr, out_valid, out_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rddata = '0, out_data;
`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
  logic          par_err;
`endif

  always #5 DfiClk = ~DfiClk;

  dwc_ddrphy_pmu_acsm_rdseq #(.DATAWID(DW), .DEPTH(DEPTH), .LOOPWID(LW)) dut (
    .DfiClk(DfiClk), .Reset_n(Reset_n), .start(start), .start_addr(start_addr),
    .stop_addr(stop_addr), .loop_cnt(loop_cnt), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted),
`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
    .par_err(par_err),
`endif
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_wr(ram_wr), .ram_rddata(ram_rddata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // RAM model: registered address, data one cycle after ce
  logic [DW-1:0] mem [DEPTH];
  always @(posedge DfiClk) if (ram_ce) ram_rddata <= mem[ram_addr];

  function automatic logic [DW-1:0] word(input int a);
    logic [DW-2:0] lo;
    lo = {7'(a), 32'hA5C3_0000 ^ (32'(a) * 32'h0101_0101), 32'(a) + 32'h1234};
    return {^lo, lo};
  endfunction

  int tests = 0, failed = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb[$];

  task automatic push_seq(input int s, input int e, input int loops);
    exp_t x;
    for (int p = 0; p <= loops; p++) begin
      int a;
      a = s;
      forever begin
        x.d = word(a);
        x.l = (a == e) && (p == loops);
        sb.push_back(x);
        if (a == e) break;
        a = (a + 1) % DEPTH;
      end
    end
  endtask

  int  cyc = 0;
  always @(posedge DfiClk) cyc++;

  // Monitor: scoreboard pops on transfers; backpressure rules checked when bp_mode is set
  bit            bp_mode = 1'b0, prev_stall = 1'b0;
  int            outst = 0, xfers = 0, last_xfer_cyc = 0;
  logic [DW:0]   prev_dl = '0;
  always @(negedge DfiClk) begin
    if (Reset_n) begin
      if (bp_mode) begin
        if (ram_ce && !out_ready) chk("bp_issue_room", outst < 2, 1'b1);
        if (prev_stall) begin
          chk("bp_hold_valid", out_valid, 1'b1);
          chk("bp_hold_data", {out_last, out_data}, prev_dl);
        end
        outst      = outst + int'(ram_ce) - int'(out_valid & out_ready);
        prev_stall = out_valid & ~out_ready;
        prev_dl    = {out_last, out_data};
      end else begin
        outst      = 0;
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        exp_t e;
        xfers++;
        if (out_last) last_xfer_cyc = cyc;
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
      end
    end
  end

  task automatic do_start(input int s, input int e, input int l);
    @(posedge DfiClk); #2;
    start = 1'b1; start_addr = AW'(s); stop_addr = AW'(e); loop_cnt = LW'(l);
    push_seq(s, e, l);
    @(posedge DfiClk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag, input logic exp_ab);
    for (int n = 0; n < maxc; n++) begin
      @(negedge DfiClk);
      if (done) break;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_aborted"}, aborted, exp_ab);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    bit got;
    logic [3:0]    pat;
    logic [DW-1:0] saved;
    pat = 4'b1001;
    for (int a = 0; a < DEPTH; a++) mem[a] = word(a);

    // reset state
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_ctl", {busy, done, aborted, ram_ce, ram_wr, out_valid, out_last}, 7'b0);
    chk("rst_addr", ram_addr, 4'd0);
    chk("rst_data", out_data, 72'd0);
    repeat (2) @(posedge DfiClk);
    #2 Reset_n = 1'b1;

    // basic pass 4..7
    do_start(4, 7, 0);
    @(negedge DfiClk);
    chk("t1_busy", busy, 1'b1);
    chk("t1_c1_valid", out_valid, 1'b0);
    chk("t1_first_issue", {ram_ce, ram_addr}, {1'b1, 4'd4});
    @(negedge DfiClk);
    chk("t1_c2_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge DfiClk);
      chk("t1_stream_valid", out_valid, 1'b1);
    end
    @(negedge DfiClk);
    chk("t1_done", done, 1'b1);
    chk("t1_aborted", aborted, 1'b0);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_done_lat", cyc - last_xfer_cyc, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_ram_wr", ram_wr, 1'b0);
    @(negedge DfiClk);
    chk("t1_done_pulse", done, 1'b0);

    // wrapping range with one extra pass
    x0 = xfers;
    do_start(14, 1, 1);
    wait_done(40, "t2", 1'b0);
    chk("t2_count", xfers - x0, 8);
    chk("t2_sb_empty", sb.size(), 0);

    // backpressure 1,0,0,1 on a 3-entry range
    bp_mode = 1'b1;
    x0 = xfers;
    got = 1'b0;
    do_start(2, 4, 0);
    for (int i = 0; i < 80; i++) begin
      @(posedge DfiClk); #2;
      out_ready = pat[i % 4];
      @(negedge DfiClk);
      if (done) begin got = 1'b1; break; end
    end
    chk("t3_done", got, 1'b1);
    chk("t3_aborted", aborted, 1'b0);
    bp_mode = 1'b0;
    out_ready = 1'b1;
    chk("t3_count", xfers - x0, 3);
    chk("t3_sb_empty", sb.size(), 0);

    // abort during the third issue of a 10-entry run
    x0 = xfers;
    do_start(0, 9, 0);
    @(posedge DfiClk); #2;
    @(posedge DfiClk); #2 abort = 1'b1;
    @(negedge DfiClk);
    chk("t4_stop_issue", ram_ce, 1'b0);
    @(posedge DfiClk); #2 abort = 1'b0;
    @(negedge DfiClk);
    chk("t4_valid_drop", out_valid, 1'b0);
    wait_done(2, "t4", 1'b1);
    chk("t4_count", xfers - x0, 1);
    sb.delete();
    @(negedge DfiClk);
    chk("t4_sticky", {aborted, done}, 2'b10);
    // abort in IDLE is ignored
    @(posedge DfiClk); #2 abort = 1'b1;
    @(negedge DfiClk);
    chk("t4_idle_abort", {busy, done}, 2'b00);
    @(posedge DfiClk); #2 abort = 1'b0;
    x0 = xfers;
    do_start(3, 5, 0);
    @(negedge DfiClk);
    chk("t4_aborted_clr", aborted, 1'b0);
    wait_done(20, "t4b", 1'b0);
    chk("t4b_count", xfers - x0, 3);
    chk("t4b_sb_empty", sb.size(), 0);

    // single entry, 256 passes, with an ignored start while busy
    x0 = xfers;
    do_start(0, 0, 255);
    repeat (10) @(posedge DfiClk);
    #2 start = 1'b1; start_addr = 4'd9; stop_addr = 4'd9; loop_cnt = 8'd0;
    @(posedge DfiClk); #2 start = 1'b0;
    wait_done(400, "t5", 1'b0);
    chk("t5_count", xfers - x0, 256);
    chk("t5_sb_empty", sb.size(), 0);

`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
    // corrupted parity at address 5
    saved = mem[5];
    mem[5][0] = ~mem[5][0];
    do_start(3, 8, 0);
    wait_done(20, "t6", 1'b1);
    chk("t6_par_err", par_err, 1'b1);
    mem[5] = saved;
    sb.delete();
`else
    saved = '0;
`endif

    // reset mid-run
    do_start(2, 9, 0);
    @(negedge DfiClk);
    chk("t7_running", busy, 1'b1);
`ifdef DWC_DDRPHY_ACSM_RDSEQ_PARITY_EN
    chk("t7_par_clr", par_err, 1'b0);
`endif
    @(posedge DfiClk); #2 Reset_n = 1'b0;
    #1;
    chk("t7_rst_ctl", {busy, done, aborted, ram_ce, out_valid, out_last}, 6'b0);
    chk("t7_rst_addr", ram_addr, 4'd0);
    @(posedge DfiClk); #2 Reset_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge DfiClk);
      chk("t7_no_done", {busy, done}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
